// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths, NOP encoding and fetch-queue entry type
// for the instruction fetch stage.
package if_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc4;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// fetch_fifo: in-order instruction queue with flush.
// The head comes straight from storage; an empty queue reads as a zero entry.
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head = empty ? fetch_entry_t'{pc4: '0, inst: NOP}
                      : mem[rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: credit-based instruction fetch with redirect and stale-response discard.
// Define IF_FETCH_PERF_CNT_EN to add the perf_stall_o stall-cycle counter.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc4_o,
  output logic [ILEN-1:0] id_inst_o
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_o
`endif
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DMAX = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] resp_pc_nxt;
  logic [XLEN-1:0] target;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] discard;
  logic [CW-1:0] disc_nxt;
  logic [CW-1:0] occ;

  logic [CW:0] used;
  logic [CW:0] limit;

  logic grant;
  logic pop;
  logic rsp;
  logic push;

  fetch_entry_t wdata;
  fetch_entry_t head;
  logic         full;
  logic         empty;

  assign target = word_align(redirect_pc_i);
  assign pop    = id_valid_o & id_ready_i;

  // A pop this cycle frees its slot, which sustains one fetch per cycle.
  assign used  = {1'b0, outstanding} + {1'b0, occ};
  assign limit = DMAX + {{CW{1'b0}}, pop};

  assign imem_req_o  = start_i & ~rst_i & (used < limit);
  assign imem_addr_o = pc;
  assign grant       = imem_req_o & imem_gnt_i;

  assign rsp  = imem_rvalid_i & (outstanding != '0);
  assign push = rsp & (discard == '0) & ~redirect_i
              & (~full | pop);

  assign wdata = '{pc4: resp_pc + 32'd4, inst: imem_rdata_i};

  always_comb begin
    out_nxt     = outstanding + CW'(grant) - CW'(rsp);
    disc_nxt    = discard;
    pc_nxt      = pc;
    resp_pc_nxt = resp_pc;
    if (redirect_i) begin
      disc_nxt    = out_nxt;
      pc_nxt      = target;
      resp_pc_nxt = target;
    end else begin
      if (rsp && discard != '0) disc_nxt = discard - CW'(1);
      if (grant) pc_nxt = pc + 32'd4;
      if (push) resp_pc_nxt = resp_pc + 32'd4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc          <= word_align(RESET_PC);
      resp_pc     <= word_align(RESET_PC);
      outstanding <= '0;
      discard     <= '0;
    end else begin
      pc          <= pc_nxt;
      resp_pc     <= resp_pc_nxt;
      outstanding <= out_nxt;
      discard     <= disc_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flush (redirect_i),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  assign id_valid_o = ~empty;
  assign id_pc4_o   = head.pc4;
  assign id_inst_o  = head.inst;

`ifdef IF_FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_o <= '0;
    end else if (start_i && id_ready_i && !id_valid_o
                 && perf_stall_o != '1) begin
      perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized memory/decode environment with an
// address-level reference model of the fetch stream.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, start, gnt, rvalid, redirect, id_ready;
  logic [31:0] rdata, redirect_pc;
  logic        req, valid;
  logic [31:0] addr, pc4, inst;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] perf;
  logic [31:0] s_perf;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .id_valid_o    (valid),
    .id_ready_i    (id_ready),
    .id_pc4_o      (pc4),
    .id_inst_o     (inst)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .perf_stall_o  (perf)
`endif
  );

  typedef struct {
    logic [31:0] a;
    bit          stale;
    int          due;
  } pend_t;

  pend_t        pend[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  pops[$];
  logic [31:0]  mpc;

  int cyc, n_vec, n_bad, dut_pops;
  int gnt_pct, rv_pct, lat_x, rdy_pct, redir_pm;
  bit redir_one, start_rand;
  logic [31:0] redir_tgt;

  logic        s_req, s_valid, s_fire, s_rv;
  logic [31:0] s_addr, s_pc4;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic drive();
    id_ready = ($urandom_range(0, 99) < rdy_pct);
    gnt      = ($urandom_range(0, 99) < gnt_pct);
    if (pend.size() != 0 && pend[0].due <= cyc &&
        $urandom_range(0, 99) < rv_pct) begin
      rvalid = 1'b1;
      rdata  = memw(pend[0].a);
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    if (redir_one) begin
      redirect    = 1'b1;
      redirect_pc = redir_tgt;
      redir_one   = 1'b0;
    end else if ($urandom_range(0, 999) < redir_pm) begin
      redirect    = 1'b1;
      redirect_pc = $urandom;
    end else begin
      redirect    = 1'b0;
      redirect_pc = $urandom;
    end
    if (start_rand) start = ($urandom_range(0, 9) != 0);
  endtask

  task automatic check_cycle();
    bit    ev, mpop, ereq;
    int    occ;
    pend_t r;
    ev   = (exp_q.size() != 0);
    mpop = ev && id_ready;
    occ  = pend.size() + exp_q.size() - (mpop ? 1 : 0);
    ereq = start && !rst && (occ < DEPTH);
    n_vec++;
    if (valid !== ev) begin
      n_bad++;
      $display("FAIL id_valid cyc=%0d got=%b exp=%b", cyc, valid, ev);
    end
    if (ev) begin
      n_vec++;
      if (pc4 !== exp_q[0].pc4 || inst !== exp_q[0].inst) begin
        n_bad++;
        $display("FAIL id_head cyc=%0d got=%h/%h exp=%h/%h", cyc,
                 pc4, inst, exp_q[0].pc4, exp_q[0].inst);
      end
    end
    n_vec++;
    if (req !== ereq) begin
      n_bad++;
      $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, req, ereq);
    end
    if (req === 1'b1) begin
      n_vec++;
      if (addr !== mpc) begin
        n_bad++;
        $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, addr, mpc);
      end
    end
    s_req   = req;
    s_valid = valid;
    s_addr  = addr;
    s_pc4   = pc4;
    s_fire  = (req === 1'b1) && gnt;
    s_rv    = rvalid;
`ifdef IF_FETCH_PERF_CNT_EN
    s_perf  = perf;
`endif
    if (valid === 1'b1 && id_ready === 1'b1) dut_pops++;
    if (mpop) begin
      pops.push_back(exp_q[0].pc4);
      void'(exp_q.pop_front());
    end
    if (redirect) exp_q.delete();
    if (rvalid) begin
      r = pend.pop_front();
      if (!r.stale && !redirect)
        exp_q.push_back('{pc4: r.a + 32'd4, inst: memw(r.a)});
    end
    if (req === 1'b1 && gnt) begin
      pend.push_back('{a: mpc, stale: redirect,
                       due: cyc + 1 + int'($urandom_range(0, lat_x))});
      if (!redirect) mpc = mpc + 32'd4;
    end
    if (redirect) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      mpc = {redirect_pc[31:2], 2'b00};
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    rst = 1'b1; start = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    redirect = 1'b0; id_ready = 1'b0; rdata = '0; redirect_pc = '0;
    pend.delete(); exp_q.delete(); pops.delete();
    mpc = RPC; redir_one = 1'b0; redir_pm = 0; start_rand = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic flow();
    start = 1'b1; gnt_pct = 100; rv_pct = 100; lat_x = 0; rdy_pct = 100;
  endtask

  task automatic wait_pops(input int n);
    int t;
    t = 0;
    while (pops.size() < n && t < 60) begin
      tick();
      t++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    #2;
    n_vec++;
    if (req !== 1'b0) begin n_bad++; $display("FAIL rst_req got=%b exp=0", req); end
    n_vec++;
    if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
    n_vec++;
    if (pc4 !== 32'h0) begin n_bad++; $display("FAIL rst_pc4 got=%h exp=0", pc4); end
    n_vec++;
    if (inst !== 32'h0) begin n_bad++; $display("FAIL rst_inst got=%h exp=0", inst); end
    n_vec++;
    if (addr !== RPC) begin n_bad++; $display("FAIL rst_addr got=%h exp=%h", addr, RPC); end
`ifdef IF_FETCH_PERF_CNT_EN
    n_vec++;
    if (perf !== 32'h0) begin n_bad++; $display("FAIL rst_perf got=%h exp=0", perf); end
`endif
    @(posedge clk); #1;
    start = 1'b1; #1;
    n_vec++;
    if (req !== 1'b0) begin n_bad++; $display("FAIL rst_req_start got=%b exp=0", req); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; #1;
    n_vec++;
    if (addr !== RPC || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_rst got=%h/%b exp=%h/0", addr, valid, RPC);
    end
  endtask

  task automatic test_stream();
    reset_dut();
    flow();
    repeat (6) tick();
    n_vec++;
    if (pops.size() < 3 || pops[0] !== 32'h104 ||
        pops[1] !== 32'h108 || pops[2] !== 32'h10C) begin
      n_bad++;
      $display("FAIL stream_seq got=%h,%h,%h exp=104,108,10c",
               pops[0], pops[1], pops[2]);
    end
    dut_pops = 0;
    repeat (20) tick();
    n_vec++;
    if (dut_pops != 20) begin
      n_bad++;
      $display("FAIL throughput got=%0d exp=20", dut_pops);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] h;
    bit          bad;
    pops.delete();
    repeat (5) tick();
    rdy_pct = 0;
    tick();
    h = s_pc4;
    repeat (4) begin
      tick();
      n_vec++;
      if (s_pc4 !== h || s_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL hold got=%h/%b exp=%h/1", s_pc4, s_valid, h);
      end
    end
    n_vec++;
    if (s_req !== 1'b0) begin n_bad++; $display("FAIL stall_req got=%b exp=0", s_req); end
    n_vec++;
    if (pend.size() + exp_q.size() > DEPTH) begin
      n_bad++;
      $display("FAIL credit got=%0d exp<=%0d", pend.size() + exp_q.size(), DEPTH);
    end
    rdy_pct = 100;
    repeat (15) tick();
    bad = (pops.size() < 15);
    for (int i = 1; i < pops.size(); i++)
      if (pops[i] !== pops[i-1] + 32'd4) bad = 1'b1;
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL bp_order got=%0d pops exp=consecutive", pops.size());
    end
  endtask

  task automatic test_redirect();
    reset_dut();
    flow();
    rv_pct = 0;
    repeat (4) tick();
    n_vec++;
    if (pend.size() != 2) begin
      n_bad++;
      $display("FAIL outstanding got=%0d exp=2", pend.size());
    end
    redir_one = 1'b1; redir_tgt = 32'h2002;
    tick();
    pops.delete();
    rv_pct = 100;
    tick();
    n_vec++;
    if (s_addr !== 32'h2000) begin n_bad++; $display("FAIL redir_addr got=%h exp=2000", s_addr); end
    n_vec++;
    if (s_valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid got=%b exp=0", s_valid); end
    wait_pops(1);
    n_vec++;
    if (pops.size() == 0 || pops[0] !== 32'h2004) begin
      n_bad++;
      $display("FAIL redir_first got=%h n=%0d exp=2004", pops[0], pops.size());
    end
  endtask

  task automatic test_redirect_grant();
    reset_dut();
    flow();
    repeat (6) tick();
    redir_one = 1'b1; redir_tgt = 32'h3000;
    tick();
    n_vec++;
    if (!(s_fire && s_rv)) begin
      n_bad++;
      $display("FAIL rg_setup got=%b/%b exp=1/1", s_fire, s_rv);
    end
    pops.delete();
    tick();
    n_vec++;
    if (s_valid !== 1'b0) begin n_bad++; $display("FAIL rg_valid got=%b exp=0", s_valid); end
    n_vec++;
    if (s_addr !== 32'h3000) begin n_bad++; $display("FAIL rg_addr got=%h exp=3000", s_addr); end
    wait_pops(1);
    n_vec++;
    if (pops.size() == 0 || pops[0] !== 32'h3004) begin
      n_bad++;
      $display("FAIL rg_first got=%h n=%0d exp=3004", pops[0], pops.size());
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    flow();
    repeat (3) tick();
    redir_one = 1'b1; redir_tgt = 32'hFFFF_FFF8;
    tick();
    pops.delete();
    wait_pops(3);
    n_vec++;
    if (pops.size() < 3 || pops[0] !== 32'hFFFF_FFFC ||
        pops[1] !== 32'h0 || pops[2] !== 32'h4) begin
      n_bad++;
      $display("FAIL wrap got=%h,%h,%h exp=fffffffc,0,4", pops[0], pops[1], pops[2]);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    flow();
    repeat (5) tick();
    #2;
    rst = 1'b1; rvalid = 1'b0;
    #1;
    n_vec++;
    if (req !== 1'b0 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst_ctl got=%b/%b exp=0/0", req, valid);
    end
    n_vec++;
    if (pc4 !== 32'h0 || inst !== 32'h0 || addr !== RPC) begin
      n_bad++;
      $display("FAIL mid_rst_data got=%h/%h/%h exp=0/0/%h", pc4, inst, addr, RPC);
    end
    pend.delete(); exp_q.delete(); mpc = RPC;
    @(posedge clk); #1;
    rst = 1'b0;
    pops.delete();
    repeat (6) tick();
    n_vec++;
    if (pops.size() == 0 || pops[0] !== RPC + 32'd4) begin
      n_bad++;
      $display("FAIL mid_rst_restart got=%h exp=%h", pops[0], RPC + 32'd4);
    end
  endtask

  task automatic test_random();
    reset_dut();
    flow();
    start_rand = 1'b1;
    redir_pm   = 20;
    for (int k = 0; k < 2500; k++) begin
      if (k % 100 == 0) begin
        gnt_pct = $urandom_range(20, 100);
        rv_pct  = $urandom_range(20, 100);
        lat_x   = $urandom_range(0, 3);
        rdy_pct = $urandom_range(10, 100);
      end
      tick();
    end
    start_rand = 1'b0; redir_pm = 0; start = 1'b0;
    rv_pct = 100; rdy_pct = 100;
    repeat (20) tick();
    n_vec++;
    if (pend.size() != 0 || exp_q.size() != 0 || s_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain got=%0d/%0d/%b exp=0/0/0", pend.size(), exp_q.size(), s_valid);
    end
  endtask

`ifdef IF_FETCH_PERF_CNT_EN
  task automatic test_perf();
    logic [31:0] base;
    reset_dut();
    flow();
    gnt_pct = 0;
    tick();
    base = s_perf;
    repeat (7) tick();
    n_vec++;
    if (!(s_perf - base >= 32'd7)) begin
      n_bad++;
      $display("FAIL perf_stall got=%0d exp>=7", s_perf - base);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0; dut_pops = 0;
    gnt_pct = 100; rv_pct = 100; lat_x = 0; rdy_pct = 100;
    redir_pm = 0; redir_one = 1'b0; start_rand = 1'b0;
    redir_tgt = '0; mpc = RPC;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_grant();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef IF_FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, gives the fetch-queue entries and the maximum outstanding memory requests; legal values are 2 or 4.
REQ-003 clk_i  in  1  Single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  Asynchronous, active-high reset.
REQ-005 start_i  in  1  Fetch enable; no new request is issued while it is low.
REQ-006 imem_req_o  out  1  Instruction-memory request valid.
REQ-007 imem_addr_o  out  32  Request word address; bits [1:0] are always 0.
REQ-008 imem_gnt_i  in  1  Request accepted when imem_req_o and imem_gnt_i are both high.
REQ-009 imem_rvalid_i  in  1  Response valid; responses return in order, at least 1 cycle after grant.
REQ-010 imem_rdata_i  in  32  Response instruction word.
REQ-011 redirect_i  in  1  Branch/jump redirect pulse from the decode/execute stages.
REQ-012 redirect_pc_i  in  32  Redirect target address.
REQ-013 id_valid_o  out  1  The queue head is valid for the IF_ID register.
REQ-014 id_ready_i  in  1  IF_ID accepts the head; a pop occurs on id_valid_o and id_ready_i.
REQ-015 id_pc4_o  out  32  The head instruction's address + 4.
REQ-016 id_inst_o  out  32  The head instruction word.

Function
REQ-017 PC register: issues imem_addr_o = PC; on a grant, PC takes PC+4, modulo 2^32 (wraps 32'hFFFF_FFFC to 0).
REQ-018 imem_req_o = start_i and not rst_i and (outstanding + queue occupancy < DEPTH); credit-based, so a response never finds the queue full.
REQ-019 imem_req_o and imem_addr_o stay stable until granted, unless redirect_i is asserted.
REQ-020 A valid imem_rvalid_i pushes {addr+4, rdata} into the queue in the same cycle and decrements outstanding, unless the response is being discarded.
REQ-021 The queue is a FIFO; id_* outputs come from the head register with no combinational path from imem_rdata_i.
REQ-022 Push and pop in the same cycle keep occupancy unchanged; a response into an empty queue is visible on id_valid_o the next cycle (1-cycle latency).
REQ-023 id_pc4_o and id_inst_o hold stable while id_valid_o is high and id_ready_i is low.
REQ-024 Redirect has priority over every other event in that cycle, with these effects:
  - PC takes {redirect_pc_i[31:2], 2'b00};
  - the queue is flushed, and id_valid_o is low the next cycle;
  - the discard counter takes all outstanding requests, including one granted in the same cycle;
  - PC does not also add 4.
REQ-025 While the discard counter is nonzero, each imem_rvalid_i decrements both the discard counter and outstanding, and pushes nothing.
REQ-026 A redirect arriving while the discard counter is nonzero adds the new outstanding requests; the counter never exceeds DEPTH.
REQ-027 A pop in the redirect cycle is still counted as accepted by IF_ID.
REQ-028 start_i falling mid-operation stops new requests only; outstanding responses are still collected and the queue still drains.

Reset
REQ-029 Asynchronous rst_i: PC=RESET_PC; queue empty; outstanding=0; discard counter=0.
REQ-030 During and after reset until the next request: imem_req_o=0, id_valid_o=0, id_pc4_o=0, id_inst_o=0, imem_addr_o=RESET_PC.
REQ-031 Responses that arrive after reset for requests granted before it are ignored; the memory is reset together with this block.

Configuration
REQ-032 Macro IF_FETCH_PERF_CNT_EN defined: adds output perf_stall_o (32-bit); it counts cycles with start_i high, id_ready_i high and id_valid_o low, saturates at 32'hFFFF_FFFF, and resets to 0.
REQ-033 Macro IF_FETCH_PERF_CNT_EN undefined: no port and no counter logic are present.

Structure
REQ-034 A shared package holds the word width (32), the instruction-width constant, the NOP encoding 32'h0000_0000, and a typedef of the fetch entry {pc4, inst}.
REQ-035 The queue is one sub-module, fetch_fifo, with a flush input, push/pop and full/empty; the credit and discard counters stay in the top level.

Verification
REQ-036 Reset with RESET_PC=32'h100, start_i=1, gnt always 1, rvalid 1 cycle later, id_ready_i=1 -> id_pc4_o sequence 104, 108, 10C, and one instruction per cycle in steady state.
REQ-037 id_ready_i low for 5 cycles, DEPTH=2 -> at most 2 requests outstanding plus queued, imem_req_o drops, and id_* stay stable; after release there is no loss or duplication.
REQ-038 Redirect to 32'h2002 with 2 requests outstanding -> next imem_addr_o=32'h2000, both stale responses dropped, and the first id_pc4_o=32'h2004.
REQ-039 Redirect in the same cycle as a grant and a push -> the granted response is discarded, the queue is empty next cycle, and the PC is not incremented past the target.
REQ-040 PC at 32'hFFFF_FFFC granted -> the next address is 0; rst_i asserted mid-burst -> all outputs reach reset values immediately, asynchronously.
REQ-041 With IF_FETCH_PERF_CNT_EN defined, gnt held low 7 cycles with id_ready_i=1 -> perf_stall_o increases by at least 7.
